pulse_sync_tx: RTL and testbench
================================

PULSE_SYNC_TX -- requirements
Module: pulse_sync_tx

Interface
REQ-001 Parameter N, default 8: width of the data word carried across the strobe interface.
REQ-002 Parameter HOLD_CYCLES, default 4: number of cycles stb is held high per transfer (legal range 1..255).
REQ-003 Parameter DRAIN_CYCLES, default 4: cycles data_out stays frozen after stb falls, covering the receiver's 2-flop strobe latency (legal range 2..255).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ena  input  1  global enable; when low, all state and counters freeze.
REQ-008 in_valid  input  1  producer offers in_data.
REQ-009 in_data  input  N  word to transmit.
REQ-010 in_ready  output  1  block can accept a word; high only in IDLE.
REQ-011 data_out  output  N  registered word driven to the receiver's data input.
REQ-012 stb  output  1  registered strobe driven to the receiver's strobe input.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, HOLD and DRAIN.
REQ-015 Acceptance SHALL occur on an edge where ena=1, in_valid=1 and state=IDLE; data_out loads in_data on that edge and the state moves to SETUP.
REQ-016 In SETUP, stb SHALL be 0 and data_out stable; after one enabled cycle the state moves to HOLD.
REQ-017 In HOLD, stb SHALL be 1 for exactly HOLD_CYCLES enabled cycles, after which the state moves to DRAIN.
REQ-018 In DRAIN, stb SHALL be 0 and data_out unchanged for exactly DRAIN_CYCLES enabled cycles, after which the state moves to IDLE.
REQ-019 With acceptance at edge k: stb SHALL be high for cycles k+1..k+HOLD_CYCLES, and IDLE SHALL be re-entered at edge k+1+HOLD_CYCLES+DRAIN_CYCLES.
REQ-020 The minimum acceptance interval SHALL be 2+HOLD_CYCLES+DRAIN_CYCLES cycles (10 with defaults).
REQ-021 data_out SHALL change only on an acceptance edge or on reset, never during SETUP, HOLD or DRAIN.
REQ-022 in_valid while busy SHALL be ignored: no data is captured and no word is queued.
REQ-023 in_ready SHALL be combinational from state only (state=IDLE) and independent of in_valid and ena.
REQ-024 With ena=0, the state, counter, stb and data_out SHALL hold; no acceptance occurs; the timing of REQ-019 counts enabled cycles only.
REQ-025 The counter SHALL be $clog2(max(HOLD_CYCLES,DRAIN_CYCLES)+1) bits wide, load HOLD_CYCLES-1 or DRAIN_CYCLES-1 on state entry, decrement to 0 and never wrap.
REQ-026 Illegal parameter values (HOLD_CYCLES<1 or DRAIN_CYCLES<2) SHALL cause an elaboration-time error.

Reset
REQ-027 While rst=1, outputs SHALL be forced immediately (asynchronously) to stb=0, data_out=0, busy=0, in_ready=1, with state IDLE and counter 0.
REQ-028 Reset asserted mid-transfer (any non-IDLE state) SHALL abort the transfer with no further stb pulse; the first acceptance is possible on the first enabled edge after rst falls.

Structure
REQ-029 Package pulse_sync_pkg SHALL hold the state enum (IDLE, SETUP, HOLD, DRAIN) and the default constants for N, HOLD_CYCLES and DRAIN_CYCLES.
REQ-030 One sub-module, pulse_sync_tx_timer, SHALL be the loadable down-counter with a done flag and ena gating; the FSM and data register stay in pulse_sync_tx.
REQ-031 All outputs except in_ready SHALL be driven directly from flops.

Verification
REQ-032 Defaults, rst released, in_valid=1 with in_data=0xA5 for 1 cycle at edge k -> data_out=0xA5 from k, stb=1 for cycles k+1..k+4, in_ready=1 again at k+9.
REQ-033 Back-to-back: in_valid held high with 0x11 then 0x22 -> 0x22 accepted exactly 10 cycles after 0x11, and data_out never changes while busy=1.
REQ-034 ena=0 for 3 cycles in the middle of HOLD -> stb high for 7 wall-clock cycles total, with data_out and state frozen during the stall.
REQ-035 rst pulsed during the second HOLD cycle -> stb=0 and data_out=0 immediately, in_ready=1; the next word is accepted normally.
REQ-036 pulse_sync_tx connected to the existing pulse_sync receiver (rst_n=~rst), 100 random words -> each word appears on the receiver's data_out in order, with no intermediate or corrupted values.
REQ-037 HOLD_CYCLES=1 and DRAIN_CYCLES=2 -> stb is a single-cycle pulse and the acceptance interval is 5 cycles.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// ---------------------------------------------------------------------------
// pulse_sync_pkg
// Shared types and default constants for the pulse-synchroniser transmitter.
//   state_e          : transmitter FSM states
//   DEF_N            : default data word width
//   DEF_HOLD_CYCLES  : default number of cycles the strobe is held high
//   DEF_DRAIN_CYCLES : default number of cycles data stays frozen after strobe
//   timerWidth()     : width of a down-counter able to hold either count
// ---------------------------------------------------------------------------
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEF_N            = 8;
  localparam int DEF_HOLD_CYCLES  = 4;
  localparam int DEF_DRAIN_CYCLES = 4;

  // Wide enough to hold max(hold, drain); the timer only ever loads count-1,
  // so this leaves one spare code and the counter never needs to wrap.
  function automatic int timerWidth(input int holdCycles, input int drainCycles);
    int maxCycles;
    maxCycles = (holdCycles > drainCycles) ? holdCycles : drainCycles;
    return $clog2(maxCycles + 1);
  endfunction

endpackage

// File: rtl/pulse_sync_tx_timer.sv
// ---------------------------------------------------------------------------
// pulse_sync_tx_timer
// Loadable down-counter used to time the HOLD and DRAIN phases.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset, clears the count
//   ena_i      : enable; with it low the count freezes and loads are ignored
//   load_i     : load loadVal_i on the next enabled edge
//   loadVal_i  : value to load (phase length minus one)
//   done_o     : count has reached zero
// ---------------------------------------------------------------------------
module pulse_sync_tx_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (ena_i) begin
      if (load_i) begin
        count_d = loadVal_i;
      end else if (count_q != '0) begin
        count_d = count_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pulse_sync_tx.sv
// ---------------------------------------------------------------------------
// pulse_sync_tx
// Transmit side of a strobe-based clock-domain crossing. A word is accepted
// in IDLE, presented on data_out for one cycle with stb low (SETUP), then stb
// is held high for HOLD_CYCLES, then data_out stays frozen for DRAIN_CYCLES
// so the receiver's two-flop strobe synchroniser can sample it safely.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   ena      : global enable; low freezes all state
//   in_valid : producer offers in_data
//   in_data  : word to transmit
//   in_ready : high in IDLE only (combinational from state)
//   data_out : registered word to the receiver
//   stb      : registered strobe to the receiver
//   busy     : registered, high whenever not IDLE
// ---------------------------------------------------------------------------
module pulse_sync_tx
  import pulse_sync_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] data_out,
  output logic         stb,
  output logic         busy
);

  localparam int CW = timerWidth(HOLD_CYCLES, DRAIN_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  // Reject parameter values that would break the phase timing.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : gHoldCheck
    $error("pulse_sync_tx: HOLD_CYCLES must be in 1..255");
  end
  if (DRAIN_CYCLES < 2 || DRAIN_CYCLES > 255) begin : gDrainCheck
    $error("pulse_sync_tx: DRAIN_CYCLES must be in 2..255");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic           stb_q, stb_d;
  logic           busy_q, busy_d;
  logic           tmrLoad;
  logic [CW-1:0]  tmrLoadVal;
  logic           tmrDone;

  pulse_sync_tx_timer #(
    .W(CW)
  ) uTimer (
    .clk_i     (clk),
    .rst_i     (rst),
    .ena_i     (ena),
    .load_i    (tmrLoad),
    .loadVal_i (tmrLoadVal),
    .done_o    (tmrDone)
  );

  // Next-state logic. stb and busy are decoded from the next state so the
  // flops carry them in step with the state register.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    stb_d      = stb_q;
    busy_d     = busy_q;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = SETUP;
            data_d  = in_data;
          end
        end
        SETUP: begin
          state_d    = HOLD;
          tmrLoad    = 1'b1;
          tmrLoadVal = HOLD_LOAD;
        end
        HOLD: begin
          if (tmrDone) begin
            state_d    = DRAIN;
            tmrLoad    = 1'b1;
            tmrLoadVal = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (tmrDone) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      stb_d  = (state_d == HOLD);
      busy_d = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign data_out = data_q;
  assign stb      = stb_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_sync_tx.sv
// ---------------------------------------------------------------------------
// tb_pulse_sync_tx
// Self-checking bench for pulse_sync_tx: default instance (H=4, D=4) plus a
// minimum-timing instance (H=1, D=2), and a behavioural receiver model.
// ---------------------------------------------------------------------------
module tb_pulse_sync_tx;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_out;
  logic       stb;
  logic       busy;

  logic       ena2;
  logic       in_valid2;
  logic [7:0] in_data2;
  logic       in_ready2;
  logic [7:0] data_out2;
  logic       stb2;
  logic       busy2;

  int passCount  = 0;
  int checkCount = 0;

  pulse_sync_tx #(
    .N(8), .HOLD_CYCLES(4), .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_out(data_out), .stb(stb), .busy(busy)
  );

  pulse_sync_tx #(
    .N(8), .HOLD_CYCLES(1), .DRAIN_CYCLES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .ena(ena2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .data_out(data_out2), .stb(stb2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: two-flop strobe synchroniser, capture on synced rising edge.
  logic       rxS1, rxS2, rxS3;
  bit         rxArm = 1'b0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rxS1 <= 1'b0;
      rxS2 <= 1'b0;
      rxS3 <= 1'b0;
    end else begin
      rxS1 <= stb;
      rxS2 <= rxS1;
      rxS3 <= rxS2;
      if (rxArm && rxS2 && !rxS3) rxQ.push_back(data_out);
    end
  end

  typedef struct {
    logic       ena;
    logic       valid;
    logic [7:0] data;
    logic       expStb;
    logic [7:0] expData;
    logic       expBusy;
    logic       expReady;
  } vec_t;

  vec_t vecs[27];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int idx);
    @(negedge clk);
    ena      = vecs[idx].ena;
    in_valid = vecs[idx].valid;
    in_data  = vecs[idx].data;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d stb", idx),      32'(stb),      32'(vecs[idx].expStb));
    checkOutput($sformatf("vec%0d data_out", idx), 32'(data_out), 32'(vecs[idx].expData));
    checkOutput($sformatf("vec%0d busy", idx),     32'(busy),     32'(vecs[idx].expBusy));
    checkOutput($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(vecs[idx].expReady));
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called just after the acceptance edge: counts edges until IDLE and stb-high cycles.
  task automatic measureTransfer(input string name, input int expEdges, input int expStb);
    int edges;
    int stbCnt;
    edges  = 0;
    stbCnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (stb) stbCnt++;
      if (in_ready) break;
    end
    checkOutput({name, " edges to idle"}, 32'(edges), 32'(expEdges));
    checkOutput({name, " stb cycles"},    32'(stbCnt), 32'(expStb));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         ok;
    bit         stable;
    int         edges;
    int         stbCnt;
    logic [7:0] word;

    //          ena valid data    stb data   busy ready
    vecs[0]  = '{1, 1, 8'hA5,   0, 8'hA5, 1, 0};
    vecs[1]  = '{1, 0, 8'h00,   1, 8'hA5, 1, 0};
    vecs[2]  = '{1, 0, 8'h00,   1, 8'hA5, 1, 0};
    vecs[3]  = '{1, 1, 8'h5A,   1, 8'hA5, 1, 0};
    vecs[4]  = '{1, 0, 8'h00,   1, 8'hA5, 1, 0};
    vecs[5]  = '{1, 0, 8'h00,   0, 8'hA5, 1, 0};
    vecs[6]  = '{1, 1, 8'h5A,   0, 8'hA5, 1, 0};
    vecs[7]  = '{1, 1, 8'h5A,   0, 8'hA5, 1, 0};
    vecs[8]  = '{1, 0, 8'h00,   0, 8'hA5, 1, 0};
    vecs[9]  = '{1, 0, 8'h00,   0, 8'hA5, 0, 1};
    vecs[10] = '{1, 1, 8'h3C,   0, 8'h3C, 1, 0};
    vecs[11] = '{1, 0, 8'h00,   1, 8'h3C, 1, 0};
    vecs[12] = '{0, 1, 8'hEE,   1, 8'h3C, 1, 0};
    vecs[13] = '{0, 1, 8'hEE,   1, 8'h3C, 1, 0};
    vecs[14] = '{0, 0, 8'h00,   1, 8'h3C, 1, 0};
    vecs[15] = '{1, 0, 8'h00,   1, 8'h3C, 1, 0};
    vecs[16] = '{1, 0, 8'h00,   1, 8'h3C, 1, 0};
    vecs[17] = '{1, 0, 8'h00,   1, 8'h3C, 1, 0};
    vecs[18] = '{1, 0, 8'h00,   0, 8'h3C, 1, 0};
    vecs[19] = '{1, 1, 8'hEE,   0, 8'h3C, 1, 0};
    vecs[20] = '{1, 0, 8'h00,   0, 8'h3C, 1, 0};
    vecs[21] = '{1, 0, 8'h00,   0, 8'h3C, 1, 0};
    vecs[22] = '{1, 0, 8'h00,   0, 8'h3C, 0, 1};
    vecs[23] = '{0, 1, 8'h77,   0, 8'h3C, 0, 1};
    vecs[24] = '{1, 1, 8'h77,   0, 8'h77, 1, 0};
    vecs[25] = '{1, 0, 8'h00,   1, 8'h77, 1, 0};
    vecs[26] = '{1, 0, 8'h00,   1, 8'h77, 1, 0};

    rst       = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ena2      = 1'b1;
    in_valid2 = 1'b0;
    in_data2  = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("reset stb",      32'(stb),      32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    checkOutput("reset busy",     32'(busy),     32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) applyStimulus(i);

    // Abort during the second HOLD cycle; reset must act without a clock edge.
    rst = 1'b1;
    #1;
    checkOutput("abort stb",      32'(stb),      32'd0);
    checkOutput("abort data_out", 32'(data_out), 32'd0);
    checkOutput("abort busy",     32'(busy),     32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("abort stb held", 32'(stb), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    @(posedge clk);
    #1;
    checkOutput("post-reset accept data", 32'(data_out), 32'hC3);
    checkOutput("post-reset accept busy", 32'(busy),     32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    measureTransfer("post-reset", 9, 4);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(posedge clk);
    #1;
    checkOutput("b2b first data", 32'(data_out), 32'h11);
    @(negedge clk);
    in_data = 8'h22;
    edges   = 0;
    stbCnt  = 0;
    stable  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (stb) stbCnt++;
      if (data_out == 8'h22) break;
      if (data_out != 8'h11) stable = 1'b0;
    end
    checkOutput("b2b interval",    32'(edges),  32'd10);
    checkOutput("b2b stb cycles",  32'(stbCnt), 32'd4);
    checkOutput("b2b data stable", 32'(stable), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    waitReady(ok);
    checkOutput("b2b return idle", 32'(ok), 32'd1);

    // Minimum timing instance.
    @(negedge clk);
    in_valid2 = 1'b1;
    in_data2  = 8'hAA;
    @(posedge clk);
    #1;
    checkOutput("min first data", 32'(data_out2), 32'hAA);
    checkOutput("min first busy", 32'(busy2),     32'd1);
    @(negedge clk);
    in_data2 = 8'hBB;
    edges    = 0;
    stbCnt   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (stb2) stbCnt++;
      if (data_out2 == 8'hBB) break;
    end
    checkOutput("min interval",   32'(edges),  32'd5);
    checkOutput("min stb cycles", 32'(stbCnt), 32'd1);
    @(negedge clk);
    in_valid2 = 1'b0;

    // Random words through the receiver model.
    rxQ.delete();
    expQ.delete();
    rxArm = 1'b1;
    for (int w = 0; w < 100; w++) begin
      waitReady(ok);
      if (!ok) checkOutput($sformatf("rand%0d ready", w), 32'(ok), 32'd1);
      word     = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = word;
      expQ.push_back(word);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitReady(ok);
    repeat (5) @(negedge clk);
    rxArm = 1'b0;
    checkOutput("rx word count", 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput($sformatf("rx word %0d", i), 32'(rxQ[i]), 32'(expQ[i]));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
